// File: rtl/rob.sv
// rob: 16-entry reorder buffer with out-of-order completion, in-order retirement and mispredict squash
module rob (
  input  logic        clk,
  input  logic        reset,
  input  logic        write_en,
  input  logic [6:0]  pd_new_in,
  input  logic [6:0]  pd_old_in,
  input  logic [31:0] pc_in,
  input  logic        complete_in,
  input  logic [4:0]  rob_fu,
  input  logic        mispredict,
  input  logic [4:0]  mispredict_tag,
  input  logic        branch,
  output logic [4:0]  rob_tag_out,
  output logic        valid_retired,
  output logic        complete_out,
  output logic        full,
  output logic        empty
);
  logic [15:0]       valid_q, valid_d, complete_q, complete_d, flush;
  logic [15:0][6:0]  pd_new_q, pd_new_d, pd_old_q, pd_old_d;
  logic [15:0][31:0] pc_q, pc_d;
  logic [3:0]        head_q, head_d, tail_q, tail_d, off_b;
  logic [4:0]        ctr, ctr_d, rob_tag_q, rob_tag_d;
  logic              valid_retired_q, complete_out_q;
  logic              retire, alloc, cmp_ok;
  logic              unused_ok;
  // The payload is consumed by the commit/free-list stage, which taps it from the entry arrays.
  assign unused_ok = ^{branch, mispredict_tag[4], pd_new_q, pd_old_q, pc_q};
  assign full  = ctr == 5'd16;
  assign empty = ctr == 5'd0;
  assign rob_tag_out   = rob_tag_q;
  assign valid_retired = valid_retired_q;
  assign complete_out  = complete_out_q;
  // Next-state: retire at head, squash younger than branch, set completions, allocate at tail.
  always_comb begin
    retire = valid_q[head_q] & complete_q[head_q];
    alloc  = write_en & ~full & ~mispredict;
    off_b  = mispredict_tag[3:0] - head_q;
    for (int i = 0; i < 16; i++)
      flush[i] = mispredict & ((4'(i) - head_q) > off_b);
    cmp_ok = complete_in & ~rob_fu[4] & valid_q[rob_fu[3:0]] & ~flush[rob_fu[3:0]] &
             ~(retire & (rob_fu[3:0] == head_q));
    valid_d    = valid_q;
    complete_d = complete_q;
    pd_new_d   = pd_new_q;
    pd_old_d   = pd_old_q;
    pc_d       = pc_q;
    if (retire) begin
      valid_d[head_q]    = 1'b0;
      complete_d[head_q] = 1'b0;
    end
    valid_d    = valid_d & ~flush;
    complete_d = complete_d & ~flush;
    if (cmp_ok) complete_d[rob_fu[3:0]] = 1'b1;
    if (alloc) begin
      valid_d[tail_q]    = 1'b1;
      complete_d[tail_q] = 1'b0;
      pd_new_d[tail_q]   = pd_new_in;
      pd_old_d[tail_q]   = pd_old_in;
      pc_d[tail_q]       = pc_in;
    end
    head_d    = head_q + {3'd0, retire};
    tail_d    = mispredict ? mispredict_tag[3:0] + 4'd1 : tail_q + {3'd0, alloc};
    ctr_d     = mispredict ? {1'b0, off_b} + 5'd1 - {4'd0, retire}
                           : ctr + {4'd0, alloc} - {4'd0, retire};
    rob_tag_d = retire ? {1'b0, head_q} : rob_tag_q;
  end
  // State and registered retirement outputs; asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q         <= '0;
      complete_q      <= '0;
      pd_new_q        <= '0;
      pd_old_q        <= '0;
      pc_q            <= '0;
      head_q          <= '0;
      tail_q          <= '0;
      ctr             <= '0;
      rob_tag_q       <= '0;
      valid_retired_q <= 1'b0;
      complete_out_q  <= 1'b0;
    end else begin
      valid_q         <= valid_d;
      complete_q      <= complete_d;
      pd_new_q        <= pd_new_d;
      pd_old_q        <= pd_old_d;
      pc_q            <= pc_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      ctr             <= ctr_d;
      rob_tag_q       <= rob_tag_d;
      valid_retired_q <= retire;
      complete_out_q  <= retire;
    end
  end
endmodule

// File: tb/tb_rob.sv
// tb_rob: table-driven directed checks of the reorder buffer
module tb_rob;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        write_en = 1'b0, complete_in = 1'b0, mispredict = 1'b0, branch = 1'b0;
  logic [6:0]  pd_new_in = '0, pd_old_in = '0;
  logic [31:0] pc_in = '0;
  logic [4:0]  rob_fu = '0, mispredict_tag = '0;
  logic [4:0]  rob_tag_out;
  logic        valid_retired, complete_out, full, empty;
  int          total = 0, passed = 0;

  typedef struct {
    bit we, mp, cin;
    int fu, mt;
    bit evr;
    int etag, ectr;
  } vec_t;
  vec_t vq[$];

  rob dut (
    .clk(clk), .reset(reset), .write_en(write_en), .pd_new_in(pd_new_in), .pd_old_in(pd_old_in),
    .pc_in(pc_in), .complete_in(complete_in), .rob_fu(rob_fu), .mispredict(mispredict),
    .mispredict_tag(mispredict_tag), .branch(branch), .rob_tag_out(rob_tag_out),
    .valid_retired(valid_retired), .complete_out(complete_out), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  function automatic vec_t mk(bit we, bit mp, bit cin, int fu, int mt, bit evr, int etag, int ectr);
    vec_t v;
    v.we = we; v.mp = mp; v.cin = cin; v.fu = fu; v.mt = mt;
    v.evr = evr; v.etag = etag; v.ectr = ectr;
    return v;
  endfunction

  task automatic add(bit we, bit mp, bit cin, int fu, int mt, bit evr, int etag, int ectr);
    vq.push_back(mk(we, mp, cin, fu, mt, evr, etag, ectr));
  endtask

  // One cycle: drive, clock, then compare just after the edge.
  task automatic apply(input vec_t v, input string nm);
    write_en       = v.we;
    mispredict     = v.mp;
    complete_in    = v.cin;
    rob_fu         = 5'(v.fu);
    mispredict_tag = 5'(v.mt);
    pd_new_in      = 7'($urandom);
    pd_old_in      = 7'($urandom);
    pc_in          = $urandom;
    branch         = 1'($urandom);
    @(posedge clk);
    #1;
    chk({nm, ".valid_retired"}, int'(valid_retired), int'(v.evr));
    chk({nm, ".complete_out"}, int'(complete_out), int'(v.evr));
    chk({nm, ".rob_tag_out"}, int'(rob_tag_out), v.etag);
    chk({nm, ".ctr"}, int'(dut.ctr), v.ectr);
    chk({nm, ".full"}, int'(full), int'(v.ectr == 16));
    chk({nm, ".empty"}, int'(empty), int'(v.ectr == 0));
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, ".valid_retired"}, int'(valid_retired), 0);
    chk({nm, ".complete_out"}, int'(complete_out), 0);
    chk({nm, ".rob_tag_out"}, int'(rob_tag_out), 0);
    chk({nm, ".ctr"}, int'(dut.ctr), 0);
    chk({nm, ".full"}, int'(full), 0);
    chk({nm, ".empty"}, int'(empty), 1);
  endtask

  initial begin
    // out-of-order completion, in-order retirement: tags 0,1,2
    add(1,0,0,0,0, 0,0,1);
    add(1,0,0,0,0, 0,0,2);
    add(1,0,0,0,0, 0,0,3);
    add(0,0,1,1,0, 0,0,3);
    add(0,0,0,0,0, 0,0,3);
    add(0,0,1,0,0, 0,0,3);
    add(0,0,0,0,0, 1,0,2);
    add(0,0,0,0,0, 1,1,1);
    add(0,0,1,2,0, 0,1,1);
    add(0,0,0,0,0, 1,2,0);
    add(0,0,0,0,0, 0,2,0);
    // mispredict flush: tags 3,4,5, squash after 3, reallocation reuses 4
    add(1,0,0,0,0, 0,2,1);
    add(1,0,0,0,0, 0,2,2);
    add(1,0,0,0,0, 0,2,3);
    add(0,0,1,5,0, 0,2,3);
    add(0,0,0,0,0, 0,2,3);
    add(1,1,0,0,3, 0,2,1);
    add(0,0,1,3,0, 0,2,1);
    add(1,0,0,0,0, 1,3,1);
    add(0,0,1,4,0, 0,3,1);
    add(0,0,0,0,0, 1,4,0);
    add(0,0,0,0,0, 0,4,0);
    // fill from head=5 with wrap, then overflow attempt and drain
    for (int k = 1; k <= 16; k++) add(1,0,0,0,0, 0,4,k);
    add(1,0,0,0,0, 0,4,16);
    add(0,0,1,5,0, 0,4,16);
    add(0,0,1,6,0, 1,5,15);
    add(1,0,0,0,0, 1,6,15);
    add(1,0,0,0,0, 0,6,16);
    add(1,1,0,0,4, 0,6,14);
    add(1,0,0,0,0, 0,6,15);

    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("reset_hold");
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_reset_state("reset_release");

    foreach (vq[i]) apply(vq[i], $sformatf("vec%0d", i));

    // asynchronous reset mid-operation, sampled before any further edge
    #2;
    reset = 1'b0;
    #1;
    chk_reset_state("async_reset");
    @(negedge clk);
    reset = 1'b1;

    // branch retires in its own mispredict cycle; flushed-tag completion is dropped
    apply(mk(1,0,0,0,0, 0,0,1), "br_alloc0");
    apply(mk(1,0,0,0,0, 0,0,2), "br_alloc1");
    apply(mk(0,0,1,0,0, 0,0,2), "br_cmp0");
    apply(mk(0,1,1,1,0, 1,0,0), "br_mp_retire");
    apply(mk(1,0,0,0,0, 0,0,1), "br_realloc1");
    apply(mk(0,0,0,0,0, 0,0,1), "br_no_stale_complete");
    apply(mk(0,0,1,1,0, 0,0,1), "br_cmp1");
    apply(mk(0,0,0,0,0, 1,1,0), "br_retire1");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
